// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHOW,
        ST_GAP
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry n holds the pattern for digit n (index 9 is leftmost).
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 render as a dash (segment g only).
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup for valid digits, dash for anything else.
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = SEG_LUT[bcd];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode display scanner: snapshot, dwell, gap.
// Optional leading-zero blanking under LEADING_ZERO_BLANK_EN.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start,
    output logic                  bcd_err
);

    localparam int CW = $clog2(REFRESH_DIV + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    state_t              state, state_d;
    logic [IW-1:0]       idx, idx_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [4*DIGITS-1:0] snap, snap_d;
    logic                err_d, load_err;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d, dec_seg;
    logic                fs_d;
    logic [3:0]          dig;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]   blank, blank_d, load_blank;
    logic                nz;

    // Blank zero digits above the most significant non-zero one.
    always_comb begin
        load_blank = '0;
        nz         = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            nz            = nz | (bcd_in[4*i +: 4] != 4'd0);
            load_blank[i] = ~nz;
        end
    end
`endif

    // Flag any out-of-range code in the value about to be loaded.
    always_comb begin
        load_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                load_err = 1'b1;
            end
        end
    end

    // Next-state logic for the scan sequence.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        snap_d  = snap;
        err_d   = bcd_err;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d = blank;
`endif
        unique case (state)
            ST_LOAD: begin
                snap_d  = bcd_in;
                idx_d   = '0;
                cnt_d   = '0;
                err_d   = load_err;
`ifdef LEADING_ZERO_BLANK_EN
                blank_d = load_blank;
`endif
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (idx == IDX_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    idx_d   = idx + 1'b1;
                    state_d = ST_SHOW;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign dig = snap_d[4*idx_d +: 4];

    bcd_to_seg7 u_dec (
        .bcd (dig),
        .seg (dec_seg)
    );

    // Outputs for the upcoming state, so registers line up with it.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        fs_d  = (state == ST_LOAD);
        if (state_d == ST_SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
            if (blank_d[idx_d]) begin
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_LOAD;
            idx         <= '0;
            cnt         <= '0;
            snap        <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
            bcd_err     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank       <= '0;
`endif
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            snap        <= snap_d;
            an          <= an_d;
            seg         <= seg_d;
            frame_start <= fs_d;
            bcd_err     <= err_d;
`ifdef LEADING_ZERO_BLANK_EN
            blank       <= blank_d;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (4 digits, dwell 3) plus a
// single-digit instance (dwell 1); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = 16'h1234;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;
    logic        bcd_err;
    logic [6:0]  seg1;
    logic [0:0]  an1;
    logic        fs1;
    logic        err1;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    always #5 clk = ~clk;

    bcd_display_scan #(.DIGITS(4), .REFRESH_DIV(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start),
        .bcd_err     (bcd_err)
    );

    bcd_display_scan #(.DIGITS(1), .REFRESH_DIV(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in[3:0]),
        .seg         (seg1),
        .an          (an1),
        .frame_start (fs1),
        .bcd_err     (err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Walk one frame from its first SHOW cycle; optionally change
    // bcd_in after cycle chg_c, and stop early before cycle stop_c.
    task automatic run_frame(input int fr,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic err, input int chg_c,
                             input logic [15:0] chg_v, input int stop_c);
        logic [6:0] segs [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        int         d;
        int         k;
        segs = '{s0, s1, s2, s3};
        for (int c = 0; c < stop_c; c++) begin
            ea = 4'hF;
            es = 7'h7F;
            ef = 1'b0;
            if (c < 16) begin
                d = c / 4;
                k = c % 4;
                if (k < 3) begin
                    ea[d] = 1'b0;
                    es    = segs[d];
                    ef    = (c == 0);
                end
            end
            check($sformatf("f%0d c%0d an", fr, c), 32'(an), 32'(ea));
            check($sformatf("f%0d c%0d seg", fr, c), 32'(seg), 32'(es));
            check($sformatf("f%0d c%0d fs", fr, c),
                  32'(frame_start), 32'(ef));
            check($sformatf("f%0d c%0d err", fr, c),
                  32'(bcd_err), 32'(err));
            if (c == chg_c) begin
                bcd_in = chg_v;
            end
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst an", 32'(an), 32'hF);
        check("rst seg", 32'(seg), 32'h7F);
        check("rst fs", 32'(frame_start), 32'h0);
        check("rst err", 32'(bcd_err), 32'h0);

        rst = 1'b1;
        tick();
        run_frame(1, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, -1, 16'h0, 17);
        run_frame(2, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 5, 16'h5678, 17);
        run_frame(3, 7'h00, 7'h78, 7'h02, 7'h12, 1'b0, 5, 16'h12A4, 17);
        run_frame(4, 7'h19, 7'h3F, 7'h24, 7'h79, 1'b1, 5, 16'h1234, 17);
        run_frame(5, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, 5, 16'h0007, 17);
        run_frame(6, 7'h78, LZ, LZ, LZ, 1'b0, 5, 16'h0000, 17);
        run_frame(7, 7'h40, LZ, LZ, LZ, 1'b0, 5, 16'h1234, 17);
        run_frame(8, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, -1, 16'h0, 9);

        rst = 1'b0;
        tick();
        check("mid rst an", 32'(an), 32'hF);
        check("mid rst seg", 32'(seg), 32'h7F);
        check("mid rst fs", 32'(frame_start), 32'h0);
        check("mid rst err", 32'(bcd_err), 32'h0);
        rst = 1'b1;
        tick();
        run_frame(9, 7'h19, 7'h30, 7'h24, 7'h79, 1'b0, -1, 16'h0, 17);

        rst = 1'b0;
        tick();
        tick();
        check("d1 rst an", 32'(an1), 32'h1);
        rst = 1'b1;
        tick();
        for (int c = 0; c < 9; c++) begin
            check($sformatf("d1 c%0d an", c), 32'(an1),
                  (c % 3 == 0) ? 32'h0 : 32'h1);
            check($sformatf("d1 c%0d fs", c), 32'(fs1),
                  (c % 3 == 0) ? 32'h1 : 32'h0);
            check($sformatf("d1 c%0d seg", c), 32'(seg1),
                  (c % 3 == 0) ? 32'h19 : 32'h7F);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
